// File: rtl/cpu_mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_arb_pkg
// Shared types and constants for the core-to-memory bus arbiter.
//   arb_state_e : IDLE (arbitrate) / ISSUE (drive mem_req_*) / WAIT (read out)
//   REQ_ID_*    : owner ids carried on mem_req_id / mem_rsp_id
//   mem_req_t   : the request latched at arbitration time
// The struct is sized by ARB_ADDR_W / ARB_DATA_W; the arbiter's ADDR_WIDTH and
// DATA_WIDTH parameters must not exceed these.
// ---------------------------------------------------------------------------
package cpu_mem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 128;

    localparam logic REQ_ID_DCACHE = 1'b0;
    localparam logic REQ_ID_ICACHE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                  id;
        logic                  read;
        logic                  write;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] data;
    } mem_req_t;

endpackage

// File: rtl/cpu_mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// cpu_mem_bus_arbiter_if
// Bundles the dcache, icache and memory-core bus signals seen by the arbiter.
//   slave  : arbiter view (cache requests and memory responses in,
//            acks / responses / memory requests / busy out)
//   master : environment view (caches and memory core), the mirror image
// ---------------------------------------------------------------------------
interface cpu_mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    // dcache side
    logic                  dc_req_read;
    logic                  dc_req_write;
    logic [ADDR_WIDTH-1:0] dc_req_addr;
    logic [DATA_WIDTH-1:0] dc_req_data;
    logic                  dc_req_ack;
    logic                  dc_rsp_valid;
    // icache side
    logic                  ic_req_read;
    logic [ADDR_WIDTH-1:0] ic_req_addr;
    logic                  ic_req_ack;
    logic                  ic_rsp_valid;
    // shared response
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic [DATA_WIDTH-1:0] rsp_data;
    // memory core side
    logic                  mem_req_id;
    logic                  mem_req_read;
    logic                  mem_req_write;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_data;
    logic                  mem_req_ready;
    logic                  mem_rsp_valid;
    logic                  mem_rsp_id;
    logic [ADDR_WIDTH-1:0] mem_rsp_addr;
    logic [DATA_WIDTH-1:0] mem_rsp_data;
    logic                  busy;

    modport slave (
        input  dc_req_read, dc_req_write, dc_req_addr, dc_req_data,
        input  ic_req_read, ic_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_id, mem_rsp_addr, mem_rsp_data,
        output dc_req_ack, dc_rsp_valid, ic_req_ack, ic_rsp_valid,
        output rsp_addr, rsp_data,
        output mem_req_id, mem_req_read, mem_req_write, mem_req_addr, mem_req_data,
        output busy
    );

    modport master (
        output dc_req_read, dc_req_write, dc_req_addr, dc_req_data,
        output ic_req_read, ic_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_id, mem_rsp_addr, mem_rsp_data,
        input  dc_req_ack, dc_rsp_valid, ic_req_ack, ic_rsp_valid,
        input  rsp_addr, rsp_data,
        input  mem_req_id, mem_req_read, mem_req_write, mem_req_addr, mem_req_data,
        input  busy
    );
endinterface

// File: rtl/cpu_mem_bus_arbiter_select.sv
// ---------------------------------------------------------------------------
// cpu_mem_arb_select
// Combinational grant choice between dcache and icache.
//   grant_en    : arbiter is in IDLE and may grant this cycle
//   dc_read/dc_write/ic_read : pending requests
//   grant_valid : a grant happens this cycle
//   grant_id    : REQ_ID_DCACHE or REQ_ID_ICACHE
// Optional macro CPU_MEM_ARB_STARVATION_GUARD_EN adds clock/reset ports and a
// counter of consecutive dcache grants taken while the icache was waiting;
// once it reaches STARVE_LIMIT the icache wins the next arbitration.
// ---------------------------------------------------------------------------
module cpu_mem_arb_select
    import cpu_mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
`ifdef CPU_MEM_ARB_STARVATION_GUARD_EN
    input  logic clock,
    input  logic reset,
`endif
    input  logic grant_en,
    input  logic dc_read,
    input  logic dc_write,
    input  logic ic_read,
    output logic grant_valid,
    output logic grant_id
);

    logic dc_want;
    assign dc_want = dc_read | dc_write;

`ifdef CPU_MEM_ARB_STARVATION_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_reg;
    logic [CNT_W-1:0] starve_cnt_next;
    logic             starved;

    assign starved = (starve_cnt_reg >= CNT_W'(STARVE_LIMIT));

    always_comb begin
        grant_valid = grant_en & (dc_want | ic_read);
        grant_id    = REQ_ID_DCACHE;
        if (ic_read && (!dc_want || starved))
            grant_id = REQ_ID_ICACHE;
    end

    // Only dcache grants taken over a waiting icache advance the count.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (grant_valid) begin
            if (grant_id == REQ_ID_ICACHE || !ic_read)
                starve_cnt_next = '0;
            else if (!starved)
                starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            starve_cnt_reg <= '0;
        else
            starve_cnt_reg <= starve_cnt_next;
    end
`else
    always_comb begin
        grant_valid = grant_en & (dc_want | ic_read);
        grant_id    = (ic_read && !dc_want) ? REQ_ID_ICACHE : REQ_ID_DCACHE;
    end
`endif

endmodule

// File: rtl/cpu_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_mem_bus_arbiter
// Registered arbiter sharing one core-to-memory bus between the dcache (id 0)
// and the icache (id 1). One transaction outstanding, dcache priority,
// responses routed back by id.
// Ports:
//   clock, reset : core clock, asynchronous active-high reset
//   bus          : cpu_mem_bus_arbiter_if.slave (cache request/ack/response,
//                  memory request/ready/response, busy)
// Optional macro CPU_MEM_ARB_STARVATION_GUARD_EN enables the icache
// starvation guard in cpu_mem_arb_select.
// ---------------------------------------------------------------------------
module cpu_mem_bus_arbiter
    import cpu_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    cpu_mem_bus_arbiter_if.slave  bus
);

    arb_state_e            state_reg, state_next;
    mem_req_t              req_reg, req_next;
    logic                  mem_rd_reg, mem_rd_next;
    logic                  mem_wr_reg, mem_wr_next;
    logic                  dc_ack_reg, dc_ack_next;
    logic                  ic_ack_reg, ic_ack_next;
    logic                  dc_rsp_reg, dc_rsp_next;
    logic                  ic_rsp_reg, ic_rsp_next;
    logic [ADDR_WIDTH-1:0] rsp_addr_reg, rsp_addr_next;
    logic [DATA_WIDTH-1:0] rsp_data_reg, rsp_data_next;

    logic grant_valid;
    logic grant_id;

    cpu_mem_arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
`ifdef CPU_MEM_ARB_STARVATION_GUARD_EN
        .clock       (clock),
        .reset       (reset),
`endif
        .grant_en    (state_reg == IDLE),
        .dc_read     (bus.dc_req_read),
        .dc_write    (bus.dc_req_write),
        .ic_read     (bus.ic_req_read),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // State register and all registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            req_reg      <= '0;
            mem_rd_reg   <= 1'b0;
            mem_wr_reg   <= 1'b0;
            dc_ack_reg   <= 1'b0;
            ic_ack_reg   <= 1'b0;
            dc_rsp_reg   <= 1'b0;
            ic_rsp_reg   <= 1'b0;
            rsp_addr_reg <= '0;
            rsp_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            req_reg      <= req_next;
            mem_rd_reg   <= mem_rd_next;
            mem_wr_reg   <= mem_wr_next;
            dc_ack_reg   <= dc_ack_next;
            ic_ack_reg   <= ic_ack_next;
            dc_rsp_reg   <= dc_rsp_next;
            ic_rsp_reg   <= ic_rsp_next;
            rsp_addr_reg <= rsp_addr_next;
            rsp_data_reg <= rsp_data_next;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        state_next    = state_reg;
        req_next      = req_reg;
        dc_ack_next   = 1'b0;
        ic_ack_next   = 1'b0;
        dc_rsp_next   = 1'b0;
        ic_rsp_next   = 1'b0;
        rsp_addr_next = rsp_addr_reg;
        rsp_data_next = rsp_data_reg;

        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ISSUE;
                    req_next.id = grant_id;
                    if (grant_id == REQ_ID_DCACHE) begin
                        // A simultaneous read and write-back: the write wins.
                        req_next.write = bus.dc_req_write;
                        req_next.read  = bus.dc_req_read & ~bus.dc_req_write;
                        req_next.addr  = ARB_ADDR_W'(bus.dc_req_addr);
                        req_next.data  = ARB_DATA_W'(bus.dc_req_data);
                    end else begin
                        req_next.write = 1'b0;
                        req_next.read  = 1'b1;
                        req_next.addr  = ARB_ADDR_W'(bus.ic_req_addr);
                        req_next.data  = '0;
                    end
                end
            end
            ISSUE: begin
                if (bus.mem_req_ready) begin
                    dc_ack_next = (req_reg.id == REQ_ID_DCACHE);
                    ic_ack_next = (req_reg.id == REQ_ID_ICACHE);
                    state_next  = req_reg.write ? IDLE : WAIT;
                end
            end
            WAIT: begin
                // Responses carrying another owner's id are dropped.
                if (bus.mem_rsp_valid && bus.mem_rsp_id == req_reg.id) begin
                    rsp_addr_next = bus.mem_rsp_addr;
                    rsp_data_next = bus.mem_rsp_data;
                    dc_rsp_next   = (req_reg.id == REQ_ID_DCACHE);
                    ic_rsp_next   = (req_reg.id == REQ_ID_ICACHE);
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Request strobes are high exactly while the next state is ISSUE.
        mem_rd_next = (state_next == ISSUE) & req_next.read;
        mem_wr_next = (state_next == ISSUE) & req_next.write;
    end

    // Output drive from the registers.
    always_comb begin
        bus.dc_req_ack    = dc_ack_reg;
        bus.ic_req_ack    = ic_ack_reg;
        bus.dc_rsp_valid  = dc_rsp_reg;
        bus.ic_rsp_valid  = ic_rsp_reg;
        bus.rsp_addr      = rsp_addr_reg;
        bus.rsp_data      = rsp_data_reg;
        bus.mem_req_id    = req_reg.id;
        bus.mem_req_read  = mem_rd_reg;
        bus.mem_req_write = mem_wr_reg;
        bus.mem_req_addr  = req_reg.addr[ADDR_WIDTH-1:0];
        bus.mem_req_data  = req_reg.data[DATA_WIDTH-1:0];
        bus.busy          = (state_reg != IDLE);
    end

endmodule

// File: tb/tb_cpu_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_bus_arbiter
// Directed bench for cpu_mem_bus_arbiter. Inputs are driven and outputs are
// sampled 1 time unit after each rising clock edge.
// Build with +define+CPU_MEM_ARB_STARVATION_GUARD_EN to exercise the
// starvation guard expectations.
// ---------------------------------------------------------------------------
module tb_cpu_mem_bus_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [127:0] a5_line  = {16{8'hA5}};
    logic [127:0] wr_line  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    logic [127:0] ic_line  = 128'hBEEF_0000_0000_0000_0000_0000_0000_CAFE;
    logic         ids [0:4];
    int           n_issue;

    always #5 clock = ~clock;

    cpu_mem_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) bus ();

    cpu_mem_bus_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (128),
        .STARVE_LIMIT (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input bit ok, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.dc_req_read   = 1'b0;
        bus.dc_req_write  = 1'b0;
        bus.dc_req_addr   = '0;
        bus.dc_req_data   = '0;
        bus.ic_req_read   = 1'b0;
        bus.ic_req_addr   = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_id    = 1'b0;
        bus.mem_rsp_addr  = '0;
        bus.mem_rsp_data  = '0;

        // ---------------- reset state ----------------
        repeat (2) tick();
        chk("rst_busy",     bus.busy === 1'b0,          bus.busy,          1'b0);
        chk("rst_dc_ack",   bus.dc_req_ack === 1'b0,    bus.dc_req_ack,    1'b0);
        chk("rst_ic_ack",   bus.ic_req_ack === 1'b0,    bus.ic_req_ack,    1'b0);
        chk("rst_dc_rsp",   bus.dc_rsp_valid === 1'b0,  bus.dc_rsp_valid,  1'b0);
        chk("rst_ic_rsp",   bus.ic_rsp_valid === 1'b0,  bus.ic_rsp_valid,  1'b0);
        chk("rst_mem_rd",   bus.mem_req_read === 1'b0,  bus.mem_req_read,  1'b0);
        chk("rst_mem_wr",   bus.mem_req_write === 1'b0, bus.mem_req_write, 1'b0);
        chk("rst_mem_addr", bus.mem_req_addr === 32'h0, bus.mem_req_addr,  32'h0);
        chk("rst_rsp_addr", bus.rsp_addr === 32'h0,     bus.rsp_addr,      32'h0);
        reset = 1'b0;
        tick();

        // ---------------- 1: dcache read at 0x100 ----------------
        bus.dc_req_read = 1'b1;
        bus.dc_req_addr = 32'h100;
        tick();
        chk("t1_issue_rd",   bus.mem_req_read === 1'b1,    bus.mem_req_read, 1'b1);
        chk("t1_issue_id",   bus.mem_req_id === 1'b0,      bus.mem_req_id,   1'b0);
        chk("t1_issue_addr", bus.mem_req_addr === 32'h100, bus.mem_req_addr, 32'h100);
        chk("t1_busy",       bus.busy === 1'b1,            bus.busy,         1'b1);
        chk("t1_no_ack_yet", bus.dc_req_ack === 1'b0,      bus.dc_req_ack,   1'b0);
        tick();
        chk("t1_hold_rd",    bus.mem_req_read === 1'b1,    bus.mem_req_read, 1'b1);
        tick();
        chk("t1_hold_rd2",   bus.mem_req_read === 1'b1,    bus.mem_req_read, 1'b1);
        bus.mem_req_ready = 1'b1;
        tick();
        chk("t1_ack",        bus.dc_req_ack === 1'b1,      bus.dc_req_ack,   1'b1);
        chk("t1_rd_cleared", bus.mem_req_read === 1'b0,    bus.mem_req_read, 1'b0);
        chk("t1_wait_busy",  bus.busy === 1'b1,            bus.busy,         1'b1);
        chk("t1_ic_rsp_a",   bus.ic_rsp_valid === 1'b0,    bus.ic_rsp_valid, 1'b0);
        bus.dc_req_read   = 1'b0;
        bus.mem_req_ready = 1'b0;
        tick();
        chk("t1_ack_pulse",  bus.dc_req_ack === 1'b0,      bus.dc_req_ack,   1'b0);
        chk("t1_no_rsp_yet", bus.dc_rsp_valid === 1'b0,    bus.dc_rsp_valid, 1'b0);
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_id    = 1'b0;
        bus.mem_rsp_addr  = 32'h100;
        bus.mem_rsp_data  = a5_line;
        tick();
        chk("t1_dc_rsp",     bus.dc_rsp_valid === 1'b1,    bus.dc_rsp_valid, 1'b1);
        chk("t1_ic_rsp_b",   bus.ic_rsp_valid === 1'b0,    bus.ic_rsp_valid, 1'b0);
        chk("t1_rsp_addr",   bus.rsp_addr === 32'h100,     bus.rsp_addr,     32'h100);
        chk("t1_rsp_data",   bus.rsp_data === a5_line,     bus.rsp_data,     a5_line);
        chk("t1_idle",       bus.busy === 1'b0,            bus.busy,         1'b0);
        bus.mem_rsp_valid = 1'b0;
        tick();
        chk("t1_rsp_pulse",  bus.dc_rsp_valid === 1'b0,    bus.dc_rsp_valid, 1'b0);
        chk("t1_data_hold",  bus.rsp_data === a5_line,     bus.rsp_data,     a5_line);
        $display("txn dcache read addr=0x100 data=0x%0h", bus.rsp_data);

        // ---------------- 2: dcache write + icache read together ----------------
        bus.dc_req_write  = 1'b1;
        bus.dc_req_addr   = 32'h200;
        bus.dc_req_data   = wr_line;
        bus.ic_req_read   = 1'b1;
        bus.ic_req_addr   = 32'h300;
        bus.mem_req_ready = 1'b1;
        tick();
        chk("t2_wr",         bus.mem_req_write === 1'b1,   bus.mem_req_write, 1'b1);
        chk("t2_wr_no_rd",   bus.mem_req_read === 1'b0,    bus.mem_req_read,  1'b0);
        chk("t2_wr_id",      bus.mem_req_id === 1'b0,      bus.mem_req_id,    1'b0);
        chk("t2_wr_addr",    bus.mem_req_addr === 32'h200, bus.mem_req_addr,  32'h200);
        chk("t2_wr_data",    bus.mem_req_data === wr_line, bus.mem_req_data,  wr_line);
        tick();
        chk("t2_wr_ack",     bus.dc_req_ack === 1'b1,      bus.dc_req_ack,    1'b1);
        chk("t2_wr_cleared", bus.mem_req_write === 1'b0,   bus.mem_req_write, 1'b0);
        chk("t2_wr_idle",    bus.busy === 1'b0,            bus.busy,          1'b0);
        $display("txn dcache write addr=0x200");
        bus.dc_req_write = 1'b0;
        tick();
        chk("t2_ic_rd",      bus.mem_req_read === 1'b1,    bus.mem_req_read,  1'b1);
        chk("t2_ic_id",      bus.mem_req_id === 1'b1,      bus.mem_req_id,    1'b1);
        chk("t2_ic_addr",    bus.mem_req_addr === 32'h300, bus.mem_req_addr,  32'h300);
        tick();
        chk("t2_ic_ack",     bus.ic_req_ack === 1'b1,      bus.ic_req_ack,    1'b1);
        chk("t2_dc_no_ack",  bus.dc_req_ack === 1'b0,      bus.dc_req_ack,    1'b0);
        bus.ic_req_read   = 1'b0;
        bus.mem_req_ready = 1'b0;

        // ---------------- 3: mismatched response id in WAIT ----------------
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_id    = 1'b0;
        bus.mem_rsp_addr  = 32'h999;
        bus.mem_rsp_data  = a5_line;
        tick();
        chk("t3_drop_ic",    bus.ic_rsp_valid === 1'b0,    bus.ic_rsp_valid, 1'b0);
        chk("t3_drop_dc",    bus.dc_rsp_valid === 1'b0,    bus.dc_rsp_valid, 1'b0);
        chk("t3_still_busy", bus.busy === 1'b1,            bus.busy,         1'b1);
        chk("t3_addr_kept",  bus.rsp_addr === 32'h100,     bus.rsp_addr,     32'h100);
        bus.mem_rsp_id   = 1'b1;
        bus.mem_rsp_addr = 32'h300;
        bus.mem_rsp_data = ic_line;
        tick();
        chk("t3_ic_rsp",     bus.ic_rsp_valid === 1'b1,    bus.ic_rsp_valid, 1'b1);
        chk("t3_dc_quiet",   bus.dc_rsp_valid === 1'b0,    bus.dc_rsp_valid, 1'b0);
        chk("t3_rsp_addr",   bus.rsp_addr === 32'h300,     bus.rsp_addr,     32'h300);
        chk("t3_rsp_data",   bus.rsp_data === ic_line,     bus.rsp_data,     ic_line);
        chk("t3_idle",       bus.busy === 1'b0,            bus.busy,         1'b0);
        bus.mem_rsp_valid = 1'b0;
        $display("txn icache read addr=0x300 data=0x%0h", bus.rsp_data);
        tick();

        // ---------------- 4: reset while in WAIT ----------------
        bus.dc_req_read   = 1'b1;
        bus.dc_req_addr   = 32'h400;
        bus.mem_req_ready = 1'b1;
        tick();
        chk("t4_issue_addr", bus.mem_req_addr === 32'h400, bus.mem_req_addr, 32'h400);
        tick();
        chk("t4_ack",        bus.dc_req_ack === 1'b1,      bus.dc_req_ack,   1'b1);
        chk("t4_wait_busy",  bus.busy === 1'b1,            bus.busy,         1'b1);
        bus.dc_req_read   = 1'b0;
        bus.mem_req_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("t4_rst_busy",   bus.busy === 1'b0,            bus.busy,         1'b0);
        chk("t4_rst_ack",    bus.dc_req_ack === 1'b0,      bus.dc_req_ack,   1'b0);
        chk("t4_rst_addr",   bus.mem_req_addr === 32'h0,   bus.mem_req_addr, 32'h0);
        chk("t4_rst_rsp_a",  bus.rsp_addr === 32'h0,       bus.rsp_addr,     32'h0);
        tick();
        reset = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_id    = 1'b0;
        bus.mem_rsp_addr  = 32'h400;
        bus.mem_rsp_data  = a5_line;
        tick();
        chk("t4_late_dc",    bus.dc_rsp_valid === 1'b0,    bus.dc_rsp_valid, 1'b0);
        chk("t4_late_ic",    bus.ic_rsp_valid === 1'b0,    bus.ic_rsp_valid, 1'b0);
        chk("t4_late_busy",  bus.busy === 1'b0,            bus.busy,         1'b0);
        chk("t4_late_data",  bus.rsp_data === 128'h0,      bus.rsp_data,     128'h0);
        bus.mem_rsp_valid = 1'b0;
        $display("txn reset during read addr=0x400 discarded");
        tick();

        // ---------------- 5: dcache continuous, icache held ----------------
        bus.dc_req_write  = 1'b1;
        bus.dc_req_addr   = 32'h500;
        bus.dc_req_data   = wr_line;
        bus.ic_req_read   = 1'b1;
        bus.ic_req_addr   = 32'h600;
        bus.mem_req_ready = 1'b1;
        n_issue = 0;
        for (int c = 0; c < 30 && n_issue < 5; c++) begin
            tick();
            if (bus.mem_req_read || bus.mem_req_write) begin
                ids[n_issue] = bus.mem_req_id;
                $display("txn grant %0d id=%0d addr=0x%0h", n_issue + 1, bus.mem_req_id, bus.mem_req_addr);
                n_issue++;
            end
        end
        chk("t5_grant_count", n_issue == 5, n_issue, 5);
        for (int g = 0; g < 4; g++) begin
            chk("t5_early_dc", ids[g] === 1'b0, ids[g], 1'b0);
        end
`ifdef CPU_MEM_ARB_STARVATION_GUARD_EN
        chk("t5_fifth_ic", ids[4] === 1'b1, ids[4], 1'b1);
`else
        chk("t5_fifth_dc", ids[4] === 1'b0, ids[4], 1'b0);
`endif
        bus.dc_req_write  = 1'b0;
        bus.ic_req_read   = 1'b0;
        bus.mem_req_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
